// File: rtl/sequence_engine.sv
// Colour-sequence store for a memory game: a free-running seed counter, a
// Galois LFSR colour source, a 32-entry colour memory and a registered read port.
module sequence_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       flash_clk,
  input  logic [5:0] current_round,
  input  logic [5:0] check_round,
  input  logic [3:0] player_input,
  output logic       result,
  output logic [3:0] led,
  output logic [5:0] seq_len
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  logic [15:0] cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] valid_q, valid_d;
  logic [5:0]  seq_len_q, seq_len_d;
  logic        result_q, result_d;
  logic [3:0]  led_q, led_d;
  logic [1:0]  mem_q [32];

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [1:0]  wr_colour;
  logic [15:0] lfsr_next;
  logic [5:0]  rd_addr;
  logic        rd_legal;
  logic [3:0]  rd_onehot;

  always_comb begin
    cnt_d     = cnt_q;
    run_d     = run_q;
    lfsr_d    = lfsr_q;
    valid_d   = valid_q;
    seq_len_d = seq_len_q;
    wr_en     = 1'b0;
    wr_addr   = current_round[4:0];
    lfsr_next = lfsr_step(lfsr_q);
    wr_colour = lfsr_next[1:0];

    if (rst_seedgen) begin
      cnt_d = 16'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      cnt_d = cnt_q + 16'd1;
    end

    // start takes precedence over a coincident load_colour
    if (start) begin
      lfsr_d = (cnt_q == 16'd0) ? LFSR_SEED : cnt_q;
    end else if (load_colour && !current_round[5]) begin
      lfsr_d           = lfsr_next;
      wr_en            = 1'b1;
      valid_d[wr_addr] = 1'b1;
      seq_len_d        = current_round + 6'd1;
    end
  end

  // Read side sees pre-edge memory and valid bits, so a concurrent write is not visible
  always_comb begin
    rd_addr   = current_round - check_round;
    rd_legal  = (check_round != 6'd0) && (check_round <= current_round) &&
                !rd_addr[5] && valid_q[rd_addr[4:0]];
    rd_onehot = onehot(mem_q[rd_addr[4:0]]);
    led_d     = (flash_clk && rd_legal) ? rd_onehot : 4'b0000;
    result_d  = rd_legal && (player_input == rd_onehot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 16'd0;
      run_q     <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      valid_q   <= 32'd0;
      seq_len_q <= 6'd0;
      result_q  <= 1'b0;
      led_q     <= 4'b0000;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      seq_len_q <= seq_len_d;
      result_q  <= result_d;
      led_q     <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_addr] <= wr_colour;
    end
  end

  assign result  = result_q;
  assign led     = led_q;
  assign seq_len = seq_len_q;

endmodule
